mem_load_seq_ctrl: RTL and testbench

//  Sequences a memory-load transaction: raises load_mem, waits for done within a

---
 rtl/mem_load_seq_ctrl.sv | 87 ++++++++
 tb/tb_mem_load_seq_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mem_load_seq_ctrl.sv
// mem_load_seq_ctrl: raises load_mem, waits a bounded window for done, retries with a one-cycle gap, flags sticky error.
module mem_load_seq_ctrl #(
    parameter int DONE_WINDOW = 5,
    parameter int MAX_RETRY   = 2,
    parameter int CNT_W       = 3,
    parameter int RTY_W       = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             done,
    output logic             load_mem,
    output logic             ready,
    output logic             busy,
    output logic             err,
    output logic [RTY_W-1:0] retry_cnt
);
    typedef enum logic [2:0] {IDLE, LOAD, GAP, READY, ERROR} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [RTY_W-1:0] retry_cnt_q, retry_cnt_d;
    logic             load_mem_q, load_mem_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [CNT_W:0]   lm_run_q, lm_run_d;
    logic             hit_q, hit_d;
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        retry_cnt_d = retry_cnt_q;
        case (state_q)
            IDLE, ERROR: if (start) begin
                state_d     = LOAD;
                wait_cnt_d  = '0;
                retry_cnt_d = '0;
            end
            LOAD: if (done) state_d = READY;
                  else if (wait_cnt_q == CNT_W'(DONE_WINDOW)) state_d = GAP;
                  else wait_cnt_d = wait_cnt_q + 1'b1;
            GAP: if (retry_cnt_q < RTY_W'(MAX_RETRY)) begin
                state_d     = LOAD;
                retry_cnt_d = retry_cnt_q + 1'b1;
                wait_cnt_d  = '0;
            end else state_d = ERROR;
            default: state_d = IDLE;
        endcase
        // Outputs are registered from the next state so they line up with it.
        load_mem_d = state_d == LOAD;
        ready_d    = state_d == READY;
        busy_d     = state_d == LOAD || state_d == GAP;
        err_d      = state_d == ERROR;
        lm_run_d   = load_mem_q ? lm_run_q + 1'b1 : '0;
        hit_d      = state_q == LOAD && done;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            retry_cnt_q <= '0;
            load_mem_q  <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            lm_run_q    <= '0;
            hit_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            load_mem_q  <= load_mem_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            lm_run_q    <= lm_run_d;
            hit_q       <= hit_d;
            assert (!ready_q || hit_q);
            assert (lm_run_q <= (CNT_W+1)'(DONE_WINDOW + 1));
            assert (!(ready_q && err_q));
        end
    end
    assign load_mem  = load_mem_q;
    assign ready     = ready_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign retry_cnt = retry_cnt_q;
endmodule

// File: tb/tb_mem_load_seq_ctrl.sv
// tb_mem_load_seq_ctrl: timeline-arithmetic reference model, per-cycle compare, directed and random stimulus.
module tb_mem_load_seq_ctrl;
    localparam int W = 5, MR = 2, P = W + 2;
    logic clk = 0, rst = 1, start = 0, done = 0;
    logic load_mem, ready, busy, err;
    logic [1:0] retry_cnt;
    int checks = 0, fails = 0;
    bit chk_en = 0;
    mem_load_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .load_mem(load_mem), .ready(ready), .busy(busy), .err(err), .retry_cnt(retry_cnt)
    );
    always #5 clk = ~clk;
    // Reference: once a transaction is accepted at edge acc, every later edge's role
    // (done sample or gap) and the retry count follow from (edge - acc) alone.
    int e = 0, acc = 0, off, a, p, m_rc = 0;
    bit act = 0, m_ready = 0, was_rdy, m_err = 0, m_load = 0, m_busy = 0;
    always @(posedge clk) begin
        e++;
        was_rdy = m_ready;
        m_ready = 0;
        if (rst) begin
            act = 0; m_err = 0; m_rc = 0;
        end else if (act) begin
            off = e - acc; a = (off - 1) / P; p = (off - 1) % P;
            if (p <= W && done) begin act = 0; m_ready = 1; m_rc = a; end
            else if (p == W + 1 && a == MR) begin act = 0; m_err = 1; m_rc = MR; end
        end else if (!was_rdy && start) begin
            act = 1; acc = e; m_err = 0;
        end
        if (act) begin
            m_load = ((e - acc) % P) <= W;
            m_busy = 1;
            m_rc   = (e - acc) / P;
        end else begin
            m_load = 0; m_busy = 0;
        end
    end
    task automatic chk(input string n, input logic [7:0] act_v, input logic [7:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", n, act_v, exp_v, $time);
        end
    endtask
    always @(negedge clk) if (chk_en) begin
        chk("m_load_mem", 8'(load_mem), 8'(m_load));
        chk("m_ready", 8'(ready), 8'(m_ready));
        chk("m_busy", 8'(busy), 8'(m_busy));
        chk("m_err", 8'(err), 8'(m_err));
        chk("m_retry_cnt", 8'(retry_cnt), 8'(m_rc));
    end
    task automatic tick(input bit s, input bit d);
        start = s; done = d;
        @(negedge clk);
    endtask
    int n, lm_cnt, rdy_cnt, dp;
    initial begin
        @(negedge clk);
        @(negedge clk);
        chk_en = 1;
        chk("rst_outputs", 8'({load_mem, ready, busy, err, retry_cnt}), 8'd0);
        rst = 0;
        tick(0, 0);
        // best case: done on first LOAD cycle
        tick(1, 0);
        chk("t1_load", 8'(load_mem), 8'd1);
        tick(0, 1);
        chk("t1_ready", 8'(ready), 8'd1);
        chk("t1_load_low", 8'(load_mem), 8'd0);
        chk("t1_rc", 8'(retry_cnt), 8'd0);
        tick(0, 0);
        chk("t1_ready_pulse", 8'(ready), 8'd0);
        // done at the last window count, no gap
        tick(1, 0);
        lm_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            lm_cnt += int'(load_mem);
            tick(0, 0);
        end
        lm_cnt += int'(load_mem);
        tick(0, 1);
        chk("t2_load_cycles", 8'(lm_cnt), 8'd6);
        chk("t2_ready", 8'(ready), 8'd1);
        tick(0, 0);
        // first attempt misses, second succeeds at wait 2
        tick(1, 0);
        repeat (6) tick(0, 0);
        chk("t3_gap_load", 8'(load_mem), 8'd0);
        chk("t3_gap_busy", 8'(busy), 8'd1);
        tick(0, 0);
        chk("t3_reload", 8'(load_mem), 8'd1);
        tick(0, 0);
        tick(0, 0);
        tick(0, 1);
        chk("t3_ready", 8'(ready), 8'd1);
        chk("t3_rc", 8'(retry_cnt), 8'd1);
        tick(0, 0);
        // done never arrives
        tick(1, 0);
        n = 1;
        while (!err && n < 40) begin tick(0, 0); n++; end
        chk("t4_err_cycle", 8'(n), 8'd22);
        chk("t4_rc", 8'(retry_cnt), 8'd2);
        repeat (3) tick(0, 0);
        chk("t4_err_held", 8'(err), 8'd1);
        tick(1, 0);
        chk("t4_err_clr", 8'(err), 8'd0);
        chk("t4_restart", 8'(load_mem), 8'd1);
        chk("t4_rc_clr", 8'(retry_cnt), 8'd0);
        tick(0, 1);
        tick(0, 0);
        // reset in the middle of LOAD
        tick(1, 0);
        repeat (3) tick(0, 0);
        rst = 1;
        tick(0, 0);
        chk("t5_rst_out", 8'({load_mem, ready, busy, err, retry_cnt}), 8'd0);
        rst = 0;
        rdy_cnt = 0;
        tick(0, 1);
        rdy_cnt += int'(ready);
        tick(0, 0);
        rdy_cnt += int'(ready);
        chk("t5_no_ready", 8'(rdy_cnt), 8'd0);
        // start+done together in IDLE, extra starts while busy, done pulses while idle
        rdy_cnt = 0;
        tick(1, 1);
        chk("t6_taken", 8'(load_mem), 8'd1);
        rdy_cnt += int'(ready);
        tick(1, 0);
        rdy_cnt += int'(ready);
        tick(1, 0);
        rdy_cnt += int'(ready);
        tick(0, 1);
        rdy_cnt += int'(ready);
        for (int k = 0; k < 8; k++) begin
            tick(0, k[0]);
            rdy_cnt += int'(ready);
        end
        chk("t6_one_ready", 8'(rdy_cnt), 8'd1);
        chk("t6_idle", 8'(busy), 8'd0);
        // randomized traffic with varying done density
        for (int blk = 0; blk < 6; blk++) begin
            dp = (blk % 3 == 0) ? 0 : (blk % 3 == 1) ? 3 : 10;
            for (int k = 0; k < 500; k++) begin
                rst = ($urandom_range(199) == 0);
                tick($urandom_range(7) == 0, dp != 0 && $urandom_range(dp - 1) == 0);
            end
        end
        rst = 0;
        tick(0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
